// File: rtl/register_file_mult_if.sv
// Bus between issue logic and register_file_mult: read/write ports, PC/CSPR loads,
// write handshake and multiplier operands/result.
interface register_file_mult_if;
    logic [3:0]  in_address_1;
    logic [3:0]  in_address_2;
    logic [3:0]  in_address_3;
    logic [3:0]  in_address_4;
    logic        read_enable;
    logic [3:0]  write_address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [3:0]  write_address_2;
    logic [31:0] write_data_2;
    logic        write_enable_2;
    logic [31:0] pc_update;
    logic        pc_write;
    logic [31:0] cspr_update;
    logic        cspr_write;
    logic [31:0] Rs;
    logic [31:0] Rm;
    logic [31:0] out_data_1;
    logic [31:0] out_data_2;
    logic [31:0] out_data_3;
    logic [31:0] pc;
    logic [31:0] cspr;
    logic        req;
    logic        ack;
    logic [31:0] result;

    modport slave (
        input  in_address_1, in_address_2, in_address_3, in_address_4, read_enable,
        input  write_address, write_data, write_enable,
        input  write_address_2, write_data_2, write_enable_2,
        input  pc_update, pc_write, cspr_update, cspr_write, Rs, Rm,
        output out_data_1, out_data_2, out_data_3, pc, cspr, req, ack, result
    );

    modport master (
        output in_address_1, in_address_2, in_address_3, in_address_4, read_enable,
        output write_address, write_data, write_enable,
        output write_address_2, write_data_2, write_enable_2,
        output pc_update, pc_write, cspr_update, cspr_write, Rs, Rm,
        input  out_data_1, out_data_2, out_data_3, pc, cspr, req, ack, result
    );
endinterface

// File: rtl/register_file_mult.sv
// 15 GPRs + PC (address 15) + CSPR, dual write / triple read, write req/ack, 32x32 multiplier.
// Optional: define REGFILE_BYPASS_EN to forward same-edge write data to the read ports.
module register_file_mult (
    input logic               clk,
    input logic               rst,
    register_file_mult_if.slave bus
);
    localparam int unsigned NUM_GPR = 15;
    localparam logic [3:0]  PC_ADDR = 4'd15;

    logic [31:0] regs      [NUM_GPR];
    logic [31:0] regs_next [NUM_GPR];
    logic [31:0] pc_q, pc_next;
    logic [31:0] cspr_q, cspr_next;
    logic [31:0] out_q [3];
    logic [31:0] rd_data [3];
    logic [3:0]  rd_addr [3];
    logic        ack_q;
    logic        commit;

    // Reserved address port; folded into a deliberately unused net.
    logic unused_addr4;
    assign unused_addr4 = ^bus.in_address_4;

    // A write commits on any enabled port unless the previous commit is still being acked.
    assign commit = (bus.write_enable | bus.write_enable_2) & ~ack_q;

    always_comb begin
        // NOTE: every target gets its hold value first so no path leaves a latch;
        // later assignments then override earlier ones, encoding port1 < port2 < pc_write.
        regs_next = regs;
        pc_next   = pc_q;
        cspr_next = bus.cspr_write ? bus.cspr_update : cspr_q;
        if (commit && bus.write_enable) begin
            if (bus.write_address == PC_ADDR) pc_next = bus.write_data;
            else                              regs_next[bus.write_address] = bus.write_data;
        end
        if (commit && bus.write_enable_2) begin
            if (bus.write_address_2 == PC_ADDR) pc_next = bus.write_data_2;
            else                                regs_next[bus.write_address_2] = bus.write_data_2;
        end
        if (bus.pc_write) pc_next = bus.pc_update;
    end

    assign rd_addr[0] = bus.in_address_1;
    assign rd_addr[1] = bus.in_address_2;
    assign rd_addr[2] = bus.in_address_3;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
`ifdef REGFILE_BYPASS_EN
            rd_data[i] = (rd_addr[i] == PC_ADDR) ? pc_next : regs_next[rd_addr[i]];
`else
            rd_data[i] = (rd_addr[i] == PC_ADDR) ? pc_q : regs[rd_addr[i]];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the file must read back zero after reset, so it is built from
            // resettable flops rather than an uninitialised RAM macro.
            for (int i = 0; i < NUM_GPR; i++) regs[i] <= '0;
            for (int i = 0; i < 3; i++)       out_q[i] <= '0;
            pc_q   <= '0;
            cspr_q <= '0;
            ack_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            regs   <= regs_next;
            pc_q   <= pc_next;
            cspr_q <= cspr_next;
            ack_q  <= commit;
            if (bus.read_enable) begin
                for (int i = 0; i < 3; i++) out_q[i] <= rd_data[i];
            end
        end
    end

    assign bus.out_data_1 = out_q[0];
    assign bus.out_data_2 = out_q[1];
    assign bus.out_data_3 = out_q[2];
    assign bus.pc         = pc_q;
    assign bus.cspr       = cspr_q;
    assign bus.ack        = ack_q;
    assign bus.req        = commit;
    // Low word of the product is the same for signed and unsigned operands.
    assign bus.result     = bus.Rs * bus.Rm;
endmodule

// File: tb/tb_register_file_mult.sv
// Self-checking bench for register_file_mult: directed test-plan steps, then random
// traffic, all compared against a behavioural model of the register file.
module tb_register_file_mult;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    register_file_mult_if bus ();
    register_file_mult dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic [31:0] m_reg [15];
    logic [31:0] m_pc, m_cspr;
    logic [31:0] m_out [3];
    logic        m_ack;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_reg[i]) m_reg[i] = '0;
        foreach (m_out[i]) m_out[i] = '0;
        m_pc = '0; m_cspr = '0; m_ack = 1'b0;
    endtask

    function automatic logic [31:0] lookup(input logic [3:0] a, input logic [31:0] regs [15],
                                           input logic [31:0] pcv);
        return (a == 4'd15) ? pcv : regs[a];
    endfunction

    // Apply the effect of one rising edge using the current bus inputs.
    task automatic model_edge();
        wr_t         wq[$];
        logic [31:0] nreg [15];
        logic [31:0] npc;
        logic [3:0]  ra [3];
        logic        allowed;
        allowed = !m_ack;
        // Writes queued lowest priority first; the last one to a target wins.
        if (allowed && bus.write_enable)   wq.push_back('{bus.write_address, bus.write_data});
        if (allowed && bus.write_enable_2) wq.push_back('{bus.write_address_2, bus.write_data_2});
        if (bus.pc_write)                  wq.push_back('{4'd15, bus.pc_update});
        nreg = m_reg;
        npc  = m_pc;
        foreach (wq[k]) begin
            if (wq[k].addr == 4'd15) npc = wq[k].data;
            else                     nreg[wq[k].addr] = wq[k].data;
        end
        ra[0] = bus.in_address_1; ra[1] = bus.in_address_2; ra[2] = bus.in_address_3;
        if (bus.read_enable) begin
            for (int i = 0; i < 3; i++) begin
`ifdef REGFILE_BYPASS_EN
                m_out[i] = lookup(ra[i], nreg, npc);
`else
                m_out[i] = lookup(ra[i], m_reg, m_pc);
`endif
            end
        end
        if (bus.cspr_write) m_cspr = bus.cspr_update;
        m_ack = allowed && (bus.write_enable || bus.write_enable_2);
        m_reg = nreg;
        m_pc  = npc;
    endtask

    task automatic check_all(input string tag);
        logic [63:0] prod;
        prod = {32'd0, bus.Rs} * {32'd0, bus.Rm};
        check({tag, ".out1"}, bus.out_data_1, m_out[0]);
        check({tag, ".out2"}, bus.out_data_2, m_out[1]);
        check({tag, ".out3"}, bus.out_data_3, m_out[2]);
        check({tag, ".pc"},   bus.pc,   m_pc);
        check({tag, ".cspr"}, bus.cspr, m_cspr);
        check({tag, ".ack"},  {31'd0, bus.ack}, {31'd0, m_ack});
        check({tag, ".req"},  {31'd0, bus.req},
              {31'd0, (bus.write_enable | bus.write_enable_2) & ~m_ack});
        check({tag, ".result"}, bus.result, prod[31:0]);
    endtask

    task automatic step(input string tag);
        if (rst) model_reset();
        else     model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        bus.in_address_1 = '0; bus.in_address_2 = '0; bus.in_address_3 = '0;
        bus.in_address_4 = '0; bus.read_enable = 1'b0;
        bus.write_address = '0; bus.write_data = '0; bus.write_enable = 1'b0;
        bus.write_address_2 = '0; bus.write_data_2 = '0; bus.write_enable_2 = 1'b0;
        bus.pc_update = '0; bus.pc_write = 1'b0;
        bus.cspr_update = '0; bus.cspr_write = 1'b0;
        bus.Rs = '0; bus.Rm = '0;
    endtask

    task automatic read3(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                         input string tag);
        bus.in_address_1 = a1; bus.in_address_2 = a2; bus.in_address_3 = a3;
        bus.read_enable = 1'b1;
        step(tag);
        bus.read_enable = 1'b0;
    endtask

    initial begin
        logic [63:0] prod;
        logic [31:0] expected;

        idle_inputs();
        rst = 1'b1;
        model_reset();
        #1;
        check_all("reset_async");
        step("reset_hold");
        rst = 1'b0;
        step("idle");

        // Every register reads zero after reset, address 15 returns pc.
        for (int a = 0; a < 15; a += 3) begin
            read3(4'(a), 4'(a + 1), 4'(a + 2), "reset_read");
            check("reset_read.const", bus.out_data_3, 32'h0);
        end
        read3(4'd15, 4'd0, 4'd14, "reset_read_pc");

        // Port 1 write, ack pulse, drop enable on ack.
        bus.write_enable = 1'b1; bus.write_address = 4'd0; bus.write_data = 32'h2;
        step("wr_p1");
        check("wr_p1.ack_high", {31'd0, bus.ack}, 32'd1);
        bus.write_enable = 1'b0;
        step("wr_p1_ack");
        check("wr_p1.ack_low", {31'd0, bus.ack}, 32'd0);

        bus.write_enable_2 = 1'b1; bus.write_address_2 = 4'd1; bus.write_data_2 = 32'h2;
        step("wr_p2");
        check("wr_p2.ack_high", {31'd0, bus.ack}, 32'd1);
        bus.write_enable_2 = 1'b0;
        step("wr_p2_ack");

        read3(4'd0, 4'd1, 4'd2, "rd_r0_r1");
        check("rd_r0.const", bus.out_data_1, 32'h2);
        check("rd_r1.const", bus.out_data_2, 32'h2);

        // Repeated multiply: 2*2, then ten doublings.
        bus.Rs = 32'h2; bus.Rm = 32'h2;
        #1;
        check("mul_first", bus.result, 32'h4);
        expected = 32'h4;
        for (int i = 0; i < 10; i++) begin
            bus.Rs = expected;
            prod = {32'd0, expected} * 64'd2;
            expected = prod[31:0];
            #1;
            check("mul_chain", bus.result, expected);
        end
        check("mul_final", bus.result, 32'h1000);

        bus.write_enable = 1'b1; bus.write_address = 4'd2; bus.write_data = expected;
        step("wr_prod");
        bus.write_enable = 1'b0;
        step("wr_prod_ack");
        read3(4'd2, 4'd0, 4'd15, "rd_prod");
        check("rd_prod.const", bus.out_data_1, 32'h1000);

        bus.Rs = 32'hFFFF_FFFF; bus.Rm = 32'h2;
        #1;
        check("mul_overflow", bus.result, 32'hFFFF_FFFE);

        // Same-target collision: port 2 wins.
        bus.write_enable = 1'b1; bus.write_address = 4'd3; bus.write_data = 32'hAAAA;
        bus.write_enable_2 = 1'b1; bus.write_address_2 = 4'd3; bus.write_data_2 = 32'h5555;
        step("collide");
        bus.write_enable = 1'b0; bus.write_enable_2 = 1'b0;
        step("collide_ack");
        read3(4'd3, 4'd3, 4'd3, "rd_collide");
        check("rd_collide.const", bus.out_data_1, 32'h5555);

        // pc_write beats a port write to address 15.
        bus.pc_write = 1'b1; bus.pc_update = 32'h0000_0100;
        bus.write_enable = 1'b1; bus.write_address = 4'd15; bus.write_data = 32'hDEAD_BEEF;
        step("pc_prio");
        check("pc_prio.const", bus.pc, 32'h0000_0100);
        bus.pc_write = 1'b0; bus.write_enable = 1'b0;
        step("pc_prio_ack");

        // Enable held across ack: blocked in the ack cycle, then a fresh write.
        bus.write_enable = 1'b1; bus.write_address = 4'd4; bus.write_data = 32'h11;
        step("hold_1");
        bus.write_data = 32'h22;
        step("hold_blocked");
        step("hold_rewrite");
        bus.write_enable = 1'b0;
        step("hold_ack");
        read3(4'd4, 4'd15, 4'd3, "rd_hold");
        check("rd_hold.const", bus.out_data_1, 32'h22);

        // Reset mid-handshake: the pending write never commits.
        bus.write_enable = 1'b1; bus.write_address = 4'd5; bus.write_data = 32'h77;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rst_mid");
        bus.write_enable = 1'b0;
        step("rst_mid_hold");
        rst = 1'b0;
        step("rst_mid_idle");
        read3(4'd5, 4'd0, 4'd15, "rd_rst_mid");
        check("rd_rst_mid.const", bus.out_data_1, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bus.in_address_1    = 4'($urandom_range(15));
            bus.in_address_2    = 4'($urandom_range(15));
            bus.in_address_3    = 4'($urandom_range(15));
            bus.in_address_4    = 4'($urandom_range(15));
            bus.read_enable     = 1'($urandom_range(1));
            bus.write_address   = 4'($urandom_range(15));
            bus.write_data      = $urandom;
            bus.write_enable    = ($urandom_range(2) == 0);
            bus.write_address_2 = 4'($urandom_range(15));
            bus.write_data_2    = $urandom;
            bus.write_enable_2  = ($urandom_range(2) == 0);
            bus.pc_update       = $urandom;
            bus.pc_write        = ($urandom_range(7) == 0);
            bus.cspr_update     = $urandom;
            bus.cspr_write      = ($urandom_range(3) == 0);
            bus.Rs              = $urandom;
            bus.Rm              = $urandom;
            #1;
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
